// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment capture block: the segment pattern
// type, the canonical hex glyphs in {A,B,C,D,E,F,G} order and the
// capture FSM state encoding.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HELD  = 2'd2
  } state_e;

  localparam seg_t SEG_0 = 7'b1111110;
  localparam seg_t SEG_1 = 7'b0110000;
  localparam seg_t SEG_2 = 7'b1101101;
  localparam seg_t SEG_3 = 7'b1111001;
  localparam seg_t SEG_4 = 7'b0110011;
  localparam seg_t SEG_5 = 7'b1011011;
  localparam seg_t SEG_6 = 7'b1011111;
  localparam seg_t SEG_7 = 7'b1110000;
  localparam seg_t SEG_8 = 7'b1111111;
  localparam seg_t SEG_9 = 7'b1111011;
  localparam seg_t SEG_A = 7'b1110111;
  localparam seg_t SEG_B = 7'b0011111;
  localparam seg_t SEG_C = 7'b1001110;
  localparam seg_t SEG_D = 7'b0111101;
  localparam seg_t SEG_E = 7'b1001111;
  localparam seg_t SEG_F = 7'b1000111;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex-to-segment table. Any pattern that is
// not one of the sixteen glyphs (blank included) is reported as illegal
// and yields nibble 0.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  seg_t       seg,
  output logic       legal,
  output logic [3:0] nibble
);

  // Map a glyph back to its hex value.
  always_comb begin
    legal  = 1'b1;
    nibble = 4'h0;
    case (seg)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Receiving end of a multiplexed 7-segment display. Inputs are registered
// once, compared against the previous registered sample, and a digit is
// accepted after STABLE_CNT identical one-hot samples. A frame is published
// with a one-cycle frame_vld_o once every digit has been captured.
// Optional feature macro SEG7_DP_EN: adds the decimal point (dp in, dp_o out)
// to the compared sample and to the captured frame.
// Output handshake: frame_vld_o is a one-cycle strobe with no back-pressure;
// nibble_o/frame_err_o (and dp_o) change only in the cycle it is high and
// hold their value until the next strobe.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an,
  input  seg_t                    seg,
`ifdef SEG7_DP_EN
  input  logic                    dp,
  output logic [NUM_DIGITS-1:0]   dp_o,
`endif
  output logic [4*NUM_DIGITS-1:0] nibble_o,
  output logic                    frame_vld_o,
  output logic                    frame_err_o,
  output state_e                  state_dbg_o
);

  localparam int CW = $clog2(STABLE_CNT + 1);

  // Sample pipeline: current registered sample and the one before it.
  logic [NUM_DIGITS-1:0] an_d, an_q, an_p_d, an_p_q;
  seg_t                  seg_d, seg_q, seg_p_d, seg_p_q;
  logic                  dp_cur, dp_prev;

  state_e                  state_d, state_q;
  logic [CW-1:0]           cnt_d, cnt_q;
  logic [NUM_DIGITS-1:0]   captured_d, captured_q;
  logic [4*NUM_DIGITS-1:0] staging_d, staging_q;
  logic                    err_flag_d, err_flag_q;
  logic [4*NUM_DIGITS-1:0] nibble_d, nibble_q;
  logic                    frame_vld_d, frame_vld_q;
  logic                    frame_err_d, frame_err_q;

  logic       one_hot, changed, capture, legal, frame_full;
  logic [3:0] dec_nibble;

`ifdef SEG7_DP_EN
  logic                  dp_d, dp_q, dp_p_d, dp_p_q;
  logic [NUM_DIGITS-1:0] dp_stg_d, dp_stg_q, dp_out_d, dp_out_q;
  assign dp_cur  = dp_q;
  assign dp_prev = dp_p_q;
  assign dp_o    = dp_out_q;
`else
  assign dp_cur  = 1'b0;
  assign dp_prev = 1'b0;
`endif

  seg7_pattern_decode u_decode (
    .seg    (seg_q),
    .legal  (legal),
    .nibble (dec_nibble)
  );

  // Shift the new sample in and derive the comparison terms.
  always_comb begin
    an_d    = an;
    seg_d   = seg;
    an_p_d  = an_q;
    seg_p_d = seg_q;
`ifdef SEG7_DP_EN
    dp_d    = dp;
    dp_p_d  = dp_q;
`endif
    one_hot = (an_q != '0) && ((an_q & (an_q - 1'b1)) == '0);
    changed = (an_q != an_p_q) || (seg_q != seg_p_q) || (dp_cur != dp_prev);
  end

  // Stability FSM: count identical one-hot samples, capture once per run.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (one_hot) begin
          state_d = TRACK;
          cnt_d   = CW'(1);
        end
      end
      TRACK: begin
        if (!one_hot) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (changed) begin
          cnt_d = CW'(1);
        end else begin
          if (cnt_q < CW'(STABLE_CNT)) cnt_d = cnt_q + 1'b1;
          if (cnt_d == CW'(STABLE_CNT)) begin
            capture = 1'b1;
            state_d = HELD;
          end
        end
      end
      HELD: begin
        if (!one_hot) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (changed) begin
          state_d = TRACK;
          cnt_d   = CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Frame assembly: publish when every digit is captured; a capture in the
  // publishing cycle seeds the next frame.
  always_comb begin
    frame_full  = &captured_q;
    captured_d  = frame_full ? '0 : captured_q;
    err_flag_d  = frame_full ? 1'b0 : err_flag_q;
    staging_d   = staging_q;
    frame_vld_d = frame_full;
    nibble_d    = frame_full ? staging_q : nibble_q;
    frame_err_d = frame_full ? err_flag_q : frame_err_q;
`ifdef SEG7_DP_EN
    dp_stg_d    = dp_stg_q;
    dp_out_d    = frame_full ? dp_stg_q : dp_out_q;
`endif
    if (capture) begin
      captured_d = captured_d | an_q;
      err_flag_d = err_flag_d | ~legal;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (an_q[i]) begin
          staging_d[4*i +: 4] = dec_nibble;
`ifdef SEG7_DP_EN
          dp_stg_d[i] = dp_q;
`endif
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_q        <= '0;
      seg_q       <= '0;
      an_p_q      <= '0;
      seg_p_q     <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      captured_q  <= '0;
      staging_q   <= '0;
      err_flag_q  <= 1'b0;
      nibble_q    <= '0;
      frame_vld_q <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SEG7_DP_EN
      dp_q        <= 1'b0;
      dp_p_q      <= 1'b0;
      dp_stg_q    <= '0;
      dp_out_q    <= '0;
`endif
    end else begin
      an_q        <= an_d;
      seg_q       <= seg_d;
      an_p_q      <= an_p_d;
      seg_p_q     <= seg_p_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      captured_q  <= captured_d;
      staging_q   <= staging_d;
      err_flag_q  <= err_flag_d;
      nibble_q    <= nibble_d;
      frame_vld_q <= frame_vld_d;
      frame_err_q <= frame_err_d;
`ifdef SEG7_DP_EN
      dp_q        <= dp_d;
      dp_p_q      <= dp_p_d;
      dp_stg_q    <= dp_stg_d;
      dp_out_q    <= dp_out_d;
`endif
    end
  end

  assign nibble_o    = nibble_q;
  assign frame_vld_o = frame_vld_q;
  assign frame_err_o = frame_err_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture: directed digit sequences, expected frames
// pushed to a queue, a negedge monitor pops on every frame_vld_o.
module tb_seg7_scan_capture;
  import seg7_pkg::*;

  localparam int ND = 4;
  localparam int W  = 4 * ND + 1;

  logic            clk;
  logic            rst_n;
  logic [ND-1:0]   an;
  seg_t            seg;
  logic [4*ND-1:0] nibble_o;
  logic            frame_vld_o;
  logic            frame_err_o;
  state_e          state_dbg;
`ifdef SEG7_DP_EN
  logic            dp;
  logic [ND-1:0]   dp_o;
`endif

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  seg7_scan_capture #(.NUM_DIGITS(ND), .STABLE_CNT(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an          (an),
    .seg         (seg),
`ifdef SEG7_DP_EN
    .dp          (dp),
    .dp_o        (dp_o),
`endif
    .nibble_o    (nibble_o),
    .frame_vld_o (frame_vld_o),
    .frame_err_o (frame_err_o),
    .state_dbg_o (state_dbg)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver: hold {an,seg} for n clock cycles; inputs change 1 time unit after an edge.
  task automatic drive(input logic [ND-1:0] a, input seg_t s, input int n);
    an  = a;
    seg = s;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic show_digit(input int d, input seg_t s, input int n);
    drive(ND'(1 << d), s, n);
  endtask

  // Show a whole frame (digit 0 first), then blank long enough for the strobe.
  task automatic show_frame(input seg_t s0, input seg_t s1, input seg_t s2, input seg_t s3,
                            input int n);
    show_digit(0, s0, n);
    show_digit(1, s1, n);
    show_digit(2, s2, n);
    show_digit(3, s3, n);
    drive('0, '0, 8);
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (frame_vld_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_frame: got nibble %h err %b, expected no frame",
                 nibble_o, frame_err_o);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("frame_nibble", 32'(nibble_o), 32'(e[4*ND-1:0]));
        check("frame_err", 32'(frame_err_o), 32'(e[W-1]));
      end
    end
  end

  initial begin
    int waited;
    rst_n = 1'b0;
    an    = '0;
    seg   = '0;
`ifdef SEG7_DP_EN
    dp    = 1'b0;
`endif
    #1;

    // 1: reset with random inputs.
    repeat (2) begin
      an  = ND'($urandom_range(0, 15));
      seg = seg_t'($urandom_range(0, 127));
      @(posedge clk);
      #1;
      check("rst_nibble", 32'(nibble_o), 32'h0);
      check("rst_vld", 32'(frame_vld_o), 32'h0);
      check("rst_err", 32'(frame_err_o), 32'h0);
    end
    an    = '0;
    seg   = '0;
    rst_n = 1'b1;
    drive('0, '0, 2);

    // 2: clean frame 3210.
    exp_q.push_back({1'b0, 16'h3210});
    show_frame(SEG_0, SEG_1, SEG_2, SEG_3, 3);

    // 3: digits too short to be accepted.
    show_frame(SEG_5, SEG_6, SEG_7, SEG_9, 2);
    check("short_hold_nibble", 32'(nibble_o), 32'h3210);

    // 4: illegal pattern on digit 2, then a clean frame clears the error.
    exp_q.push_back({1'b1, 16'h8088});
    show_frame(SEG_8, SEG_8, 7'b0000001, SEG_8, 3);
    exp_q.push_back({1'b0, 16'h7A5C});
    show_frame(SEG_C, SEG_5, SEG_A, SEG_7, 3);

    // 5: multi-hot and blank gaps between digits are ignored.
    exp_q.push_back({1'b0, 16'h46B9});
    show_digit(0, SEG_9, 3);
    drive(4'b0011, SEG_8, 5);
    show_digit(1, SEG_B, 3);
    drive(4'b0000, SEG_8, 5);
    show_digit(2, SEG_6, 3);
    drive(4'b0011, SEG_1, 5);
    show_digit(3, SEG_4, 3);
    drive('0, '0, 8);

    // 6: reset after three digits, then a full frame with no stale digits.
    show_digit(0, SEG_1, 3);
    show_digit(1, SEG_2, 3);
    show_digit(2, SEG_3, 3);
    drive('0, '0, 2);
    rst_n = 1'b0;
    drive('0, '0, 2);
    rst_n = 1'b1;
    check("mid_reset_nibble", 32'(nibble_o), 32'h0);
    check("mid_reset_err", 32'(frame_err_o), 32'h0);
    exp_q.push_back({1'b0, 16'hFEDC});
    show_frame(SEG_C, SEG_D, SEG_E, SEG_F, 3);

    // Drain: every expected frame must have been seen.
    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      @(posedge clk);
      waited++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
